// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring shift-subtract divide share one
// hi/lo register pair; one bit is processed per cycle and the signed result
// is fixed up on the final iteration into a registered result.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op;
    logic [XLEN-1:0]   hi, lo, opnd;
    logic              neg;
    logic              special;
    logic [XLEN-1:0]   special_val;

    // two's complement negation when n is set, XLEN wide
    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + ONE) : v;
    endfunction

    // two's complement negation when n is set, 2*XLEN wide product
    function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + {{XLEN{1'b0}}, ONE}) : v;
    endfunction

    // operand decode at start: signedness, magnitudes, result sign, special cases
    logic            a_sgn, b_sgn, a_neg, b_neg, neg_start;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic            accept, last_iter;

    assign a_sgn     = (funct3_i == 3'd1) || (funct3_i == 3'd2) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    assign b_sgn     = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    assign a_neg     = a_sgn & a_i[XLEN-1];
    assign b_neg     = b_sgn & b_i[XLEN-1];
    assign a_mag     = cneg(a_i, a_neg);
    assign b_mag     = cneg(b_i, b_neg);
    // REM takes the dividend's sign; everything else signs by a^b (zero for unsigned ops)
    assign neg_start = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_zero  = funct3_i[2] && (b_i == '0);
    assign div_ovf   = funct3_i[2] && !funct3_i[0] && (a_i == INT_MIN) && (b_i == '1);

    assign accept    = (state == IDLE) && start_i && !flush_i;
    assign last_iter = (state == BUSY) && !flush_i && (count == LAST_CNT);

    // one iteration step of the shared datapath
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ok;
    logic [XLEN-1:0] hi_nxt, lo_nxt, res_nxt;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : '0)};
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[XLEN];
        if (op[2]) begin
            hi_nxt = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], div_ok};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod_s = cneg_wide({hi_nxt, lo_nxt}, neg);
        if (special)
            res_nxt = special_val;
        else if (op[2])
            res_nxt = op[1] ? cneg(hi_nxt, neg) : cneg(lo_nxt, neg);
        else if (op == 3'd0)
            res_nxt = prod_s[XLEN-1:0];
        else
            res_nxt = prod_s[2*XLEN-1:XLEN];
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (flush_i) state_nxt = IDLE;
                     else if (count == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch at accept, iteration while busy, result capture on the last step
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            op          <= '0;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
            neg         <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
            result_o    <= '0;
        end else if (accept) begin
            count       <= '0;
            op          <= funct3_i;
            hi          <= '0;
            lo          <= funct3_i[2] ? a_mag : b_mag;
            opnd        <= funct3_i[2] ? b_mag : a_mag;
            neg         <= neg_start;
            special     <= div_zero | div_ovf;
            if (div_zero)
                special_val <= funct3_i[1] ? a_i : '1;
            else
                special_val <= funct3_i[1] ? '0 : a_i;
        end else if ((state == BUSY) && !flush_i) begin
            count <= count + CNT_W'(1);
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            if (last_iter) result_o <= res_nxt;
        end
    end

    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);
    assign stall_o = accept || (state == BUSY);

endmodule
